// File: rtl/tl_ul_rr_arbiter.sv
// tl_ul_rr_arbiter: round-robin N:1 TileLink-UL A/D arbiter with credits.
// Optional stats ports/counters: define TL_ARB_STATS_EN.
module tl_ul_rr_arbiter #(
  parameter int N_CLIENTS    = 2,
  parameter int IN_SRC_W     = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int IDX_W =
    (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  localparam int OUT_SRC_W = IN_SRC_W + IDX_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_CLIENTS-1:0]          in_a_valid,
  output logic [N_CLIENTS-1:0]          in_a_ready,
  input  logic [3*N_CLIENTS-1:0]        in_a_opcode,
  input  logic [3*N_CLIENTS-1:0]        in_a_param,
  input  logic [3*N_CLIENTS-1:0]        in_a_size,
  input  logic [IN_SRC_W*N_CLIENTS-1:0] in_a_source,
  input  logic [32*N_CLIENTS-1:0]       in_a_address,
  input  logic [4*N_CLIENTS-1:0]        in_a_mask,
  input  logic [32*N_CLIENTS-1:0]       in_a_data,
  input  logic [N_CLIENTS-1:0]          in_a_corrupt,
  output logic [N_CLIENTS-1:0]          in_d_valid,
  input  logic [N_CLIENTS-1:0]          in_d_ready,
  output logic [2:0]                    in_d_opcode,
  output logic [2:0]                    in_d_size,
  output logic [IN_SRC_W-1:0]           in_d_source,
  output logic                          in_d_denied,
  output logic                          in_d_corrupt,
  output logic [31:0]                   in_d_data,
  output logic                          out_a_valid,
  input  logic                          out_a_ready,
  output logic [2:0]                    out_a_opcode,
  output logic [2:0]                    out_a_param,
  output logic [2:0]                    out_a_size,
  output logic [OUT_SRC_W-1:0]          out_a_source,
  output logic [31:0]                   out_a_address,
  output logic [3:0]                    out_a_mask,
  output logic [31:0]                   out_a_data,
  output logic                          out_a_corrupt,
  input  logic                          out_d_valid,
  output logic                          out_d_ready,
  input  logic [2:0]                    out_d_opcode,
  input  logic [2:0]                    out_d_size,
  input  logic [OUT_SRC_W-1:0]          out_d_source,
  input  logic                          out_d_denied,
  input  logic                          out_d_corrupt,
  input  logic [31:0]                   out_d_data
`ifdef TL_ARB_STATS_EN
  ,
  output logic [32*N_CLIENTS-1:0]       stat_grants,
  output logic [N_CLIENTS-1:0]          stat_stall
`endif
);

  localparam int CRD_W = 4;
  localparam int BC_W  = 5;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] idle_g;
  logic [IDX_W-1:0] g;
  logic             idle_hit;
  logic [BC_W-1:0]  beat_cnt;
  logic [BC_W-1:0]  d_cnt;
  logic [CRD_W-1:0] credit [N_CLIENTS];

  logic [N_CLIENTS-1:0] credit_ok;
  logic [N_CLIENTS-1:0] eligible;
  logic [N_CLIENTS-1:0] cr_inc;
  logic [N_CLIENTS-1:0] cr_dec;

  logic             a_go;
  logic             a_fire;
  logic             a_first;
  logic             a_last;
  logic [5:0]       a_beats;
  logic [2:0]       g_op;
  logic [2:0]       g_size;
  logic [IDX_W-1:0] d_idx;
  logic             d_idx_ok;
  logic             d_fire;
  logic             d_last;
  logic [5:0]       d_beats;

  function automatic logic [5:0] beats_of(
    input logic       multi,
    input logic [2:0] size
  );
    logic [5:0] b;
    b = 6'd1;
    if (multi && size > 3'd2)
      b = 6'd1 << (size - 3'd2);
    return b;
  endfunction

  // Which clients could start a new message this cycle.
  always_comb begin
    credit_ok = '0;
    eligible  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      credit_ok[i] = credit[i] < CRD_W'(MAX_INFLIGHT);
      eligible[i]  = in_a_valid[i] && credit_ok[i];
    end
  end

  // First eligible client at or after rr_ptr.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    idle_g   = '0;
    idle_hit = 1'b0;
    j        = 0;
    jj       = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CLIENTS)
        j = j - N_CLIENTS;
      jj = IDX_W'(j);
      if (!idle_hit && eligible[jj]) begin
        idle_hit = 1'b1;
        idle_g   = jj;
      end
    end
  end

  assign g      = (state == S_BURST) ? lock_idx : idle_g;
  assign a_go   = (state == S_BURST) ? in_a_valid[g]
                                     : idle_hit;
  assign g_op   = in_a_opcode[3*int'(g) +: 3];
  assign g_size = in_a_size[3*int'(g) +: 3];

  assign out_a_valid   = reset && a_go;
  assign a_fire        = out_a_valid && out_a_ready;
  assign a_first       = (state == S_IDLE);
  assign a_beats       = beats_of(g_op == 3'd0 || g_op == 3'd1,
                                  g_size);
  assign a_last        = a_first ? (a_beats == 6'd1)
                                 : (beat_cnt == BC_W'(1));

  assign out_a_opcode  = g_op;
  assign out_a_param   = in_a_param[3*int'(g) +: 3];
  assign out_a_size    = g_size;
  assign out_a_source  =
    {g, in_a_source[IN_SRC_W*int'(g) +: IN_SRC_W]};
  assign out_a_address = in_a_address[32*int'(g) +: 32];
  assign out_a_mask    = in_a_mask[4*int'(g) +: 4];
  assign out_a_data    = in_a_data[32*int'(g) +: 32];
  assign out_a_corrupt = in_a_corrupt[g];

  // Only the current grantee sees ready.
  always_comb begin
    in_a_ready = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      in_a_ready[i] = reset && out_a_ready && a_go &&
                      (g == IDX_W'(i));
  end

  assign d_idx    = out_d_source[OUT_SRC_W-1 -: IDX_W];
  assign d_idx_ok = int'(d_idx) < N_CLIENTS;

  // Steer D to the client named by the source tag.
  always_comb begin
    in_d_valid = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      in_d_valid[i] = reset && out_d_valid && d_idx_ok &&
                      (d_idx == IDX_W'(i));
  end

  assign out_d_ready  = reset &&
                        (d_idx_ok ? in_d_ready[d_idx] : 1'b1);
  assign d_fire       = out_d_valid && out_d_ready;
  assign d_beats      = beats_of(out_d_opcode == 3'd1,
                                 out_d_size);
  assign d_last       = (d_cnt == '0) ? (d_beats == 6'd1)
                                      : (d_cnt == BC_W'(1));

  assign in_d_opcode  = out_d_opcode;
  assign in_d_size    = out_d_size;
  assign in_d_source  = out_d_source[IN_SRC_W-1:0];
  assign in_d_denied  = out_d_denied;
  assign in_d_corrupt = out_d_corrupt;
  assign in_d_data    = out_d_data;

  // A-side burst lock and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      lock_idx <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else if (a_fire) begin
      if (state == S_IDLE) begin
        if (!a_last) begin
          state    <= S_BURST;
          lock_idx <= g;
          beat_cnt <= BC_W'(a_beats - 6'd1);
        end
      end else if (a_last) begin
        state    <= S_IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt - BC_W'(1);
      end
      if (a_last)
        rr_ptr <= (int'(g) == N_CLIENTS - 1) ? '0
                                             : g + 1'b1;
    end
  end

  // D-side beats still owed by the current response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_cnt <= '0;
    end else if (d_fire) begin
      if (d_cnt == '0)
        d_cnt <= d_last ? '0 : BC_W'(d_beats - 6'd1);
      else
        d_cnt <= d_cnt - BC_W'(1);
    end
  end

  always_comb begin
    cr_inc = '0;
    cr_dec = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cr_inc[i] = a_fire && a_first && (g == IDX_W'(i));
      cr_dec[i] = d_fire && d_last && d_idx_ok &&
                  (d_idx == IDX_W'(i)) &&
                  (credit[i] != '0);
    end
  end

  // Outstanding-message credit per client.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CLIENTS; i++)
        credit[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (cr_inc[i] && !cr_dec[i])
          credit[i] <= credit[i] + CRD_W'(1);
        else if (cr_dec[i] && !cr_inc[i])
          credit[i] <= credit[i] - CRD_W'(1);
      end
    end
  end

`ifdef TL_ARB_STATS_EN
  // Count accepted first beats per client.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++)
        if (cr_inc[i])
          stat_grants[32*i +: 32] <=
            stat_grants[32*i +: 32] + 32'd1;
    end
  end

  // Flag clients held off purely by their credit limit.
  always_comb begin
    stat_stall = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      stat_stall[i] = reset && (state == S_IDLE) &&
                      in_a_valid[i] && !credit_ok[i];
  end
`endif

endmodule

// File: tb/tb_tl_ul_rr_arbiter.sv
// tb_tl_ul_rr_arbiter: directed bench for tl_ul_rr_arbiter.
// A-side scoreboard queue, immediate-assert checks.
module tb_tl_ul_rr_arbiter;

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_GET  = 3'd4;
  localparam logic [2:0] OP_ACK  = 3'd0;
  localparam logic [2:0] OP_ACKD = 3'd1;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  in_a_valid;
  logic [1:0]  in_a_ready;
  logic [5:0]  in_a_opcode;
  logic [5:0]  in_a_param;
  logic [5:0]  in_a_size;
  logic [3:0]  in_a_source;
  logic [63:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic [1:0]  in_a_corrupt;
  logic [1:0]  in_d_valid;
  logic [1:0]  in_d_ready;
  logic [2:0]  in_d_opcode;
  logic [2:0]  in_d_size;
  logic [1:0]  in_d_source;
  logic        in_d_denied;
  logic        in_d_corrupt;
  logic [31:0] in_d_data;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [2:0]  out_a_opcode;
  logic [2:0]  out_a_param;
  logic [2:0]  out_a_size;
  logic [2:0]  out_a_source;
  logic [31:0] out_a_address;
  logic [3:0]  out_a_mask;
  logic [31:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_valid;
  logic        out_d_ready;
  logic [2:0]  out_d_opcode;
  logic [2:0]  out_d_size;
  logic [2:0]  out_d_source;
  logic        out_d_denied;
  logic        out_d_corrupt;
  logic [31:0] out_d_data;
`ifdef TL_ARB_STATS_EN
  logic [63:0] stat_grants;
  logic [1:0]  stat_stall;
`endif

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
  } a_exp_t;

  a_exp_t sbq[$];
  int     checks = 0;
  int     passes = 0;

  tl_ul_rr_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .in_a_valid    (in_a_valid),
    .in_a_ready    (in_a_ready),
    .in_a_opcode   (in_a_opcode),
    .in_a_param    (in_a_param),
    .in_a_size     (in_a_size),
    .in_a_source   (in_a_source),
    .in_a_address  (in_a_address),
    .in_a_mask     (in_a_mask),
    .in_a_data     (in_a_data),
    .in_a_corrupt  (in_a_corrupt),
    .in_d_valid    (in_d_valid),
    .in_d_ready    (in_d_ready),
    .in_d_opcode   (in_d_opcode),
    .in_d_size     (in_d_size),
    .in_d_source   (in_d_source),
    .in_d_denied   (in_d_denied),
    .in_d_corrupt  (in_d_corrupt),
    .in_d_data     (in_d_data),
    .out_a_valid   (out_a_valid),
    .out_a_ready   (out_a_ready),
    .out_a_opcode  (out_a_opcode),
    .out_a_param   (out_a_param),
    .out_a_size    (out_a_size),
    .out_a_source  (out_a_source),
    .out_a_address (out_a_address),
    .out_a_mask    (out_a_mask),
    .out_a_data    (out_a_data),
    .out_a_corrupt (out_a_corrupt),
    .out_d_valid   (out_d_valid),
    .out_d_ready   (out_d_ready),
    .out_d_opcode  (out_d_opcode),
    .out_d_size    (out_d_size),
    .out_d_source  (out_d_source),
    .out_d_denied  (out_d_denied),
    .out_d_corrupt (out_d_corrupt),
    .out_d_data    (out_d_data)
`ifdef TL_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic push(input logic [2:0] src,
                      input logic [31:0] addr,
                      input logic [31:0] data);
    a_exp_t e;
    e.src  = src;
    e.addr = addr;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic set_a(input int i, input logic v,
                       input logic [2:0] op,
                       input logic [2:0] sz,
                       input logic [1:0] src,
                       input logic [31:0] addr,
                       input logic [31:0] data);
    in_a_valid[i]         = v;
    in_a_opcode[3*i +: 3] = op;
    in_a_size[3*i +: 3]   = sz;
    in_a_source[2*i +: 2] = src;
    in_a_address[32*i +: 32] = addr;
    in_a_data[32*i +: 32]    = data;
  endtask

  // Inputs are already driven; sample, score, then wait.
  task automatic a_step(input logic [1:0] exp_rdy,
                        input logic exp_vld,
                        input string tag);
    a_exp_t e;
    #1;
    chk({tag, ".rdy"}, 64'(in_a_ready), 64'(exp_rdy));
    chk({tag, ".vld"}, 64'(out_a_valid), 64'(exp_vld));
    if (out_a_valid && out_a_ready) begin
      chk({tag, ".sbq"}, 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk({tag, ".src"}, 64'(out_a_source), 64'(e.src));
        chk({tag, ".adr"}, 64'(out_a_address), 64'(e.addr));
        chk({tag, ".dat"}, 64'(out_a_data), 64'(e.data));
      end
    end
    @(negedge clock);
  endtask

  // Drive one D message, optionally toggling the target ready.
  task automatic d_run(input logic [2:0] op,
                       input logic [2:0] sz,
                       input logic [2:0] src,
                       input int nb,
                       input logic tog,
                       input logic chk_a);
    int   done;
    int   guard;
    logic r;
    done  = 0;
    guard = 0;
    r     = 1'b1;
    out_d_valid  = 1'b1;
    out_d_opcode = op;
    out_d_size   = sz;
    out_d_source = src;
    while (done < nb && guard < 40) begin
      in_d_ready         = 2'b11;
      in_d_ready[src[2]] = r;
      out_d_data         = 32'hD000_0000 + 32'(done);
      #1;
      chk("d.vld", 64'(in_d_valid), 64'(2'b01 << src[2]));
      chk("d.src", 64'(in_d_source), 64'(src[1:0]));
      chk("d.rdy", 64'(out_d_ready), 64'(r));
      chk("d.dat", 64'(in_d_data),
          64'(32'hD000_0000 + 32'(done)));
      if (chk_a)
        chk("d.ablk", 64'(in_a_ready), 64'(0));
      if (r)
        done = done + 1;
      @(negedge clock);
      guard = guard + 1;
      if (tog)
        r = ~r;
    end
    chk("d.beats", 64'(done), 64'(nb));
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
  endtask

  initial begin
    in_a_valid   = '0;
    in_a_opcode  = '0;
    in_a_param   = '0;
    in_a_size    = '0;
    in_a_source  = '0;
    in_a_address = '0;
    in_a_mask    = 8'hFF;
    in_a_data    = '0;
    in_a_corrupt = '0;
    in_d_ready   = '0;
    out_a_ready  = 1'b1;
    out_d_valid  = 1'b0;
    out_d_opcode = '0;
    out_d_size   = '0;
    out_d_source = '0;
    out_d_denied = 1'b0;
    out_d_corrupt = 1'b0;
    out_d_data   = '0;

    // Outputs held off while reset is low.
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b01, A0, 0);
    set_a(1, 1'b1, OP_GET, 3'd2, 2'b11, A1, 0);
    out_d_valid = 1'b1;
    in_d_ready  = 2'b11;
    @(negedge clock);
    #1;
    chk("rst.ardy", 64'(in_a_ready), 64'(0));
    chk("rst.avld", 64'(out_a_valid), 64'(0));
    chk("rst.dvld", 64'(in_d_valid), 64'(0));
    chk("rst.drdy", 64'(out_d_ready), 64'(0));
    @(negedge clock);
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
    reset       = 1'b1;

    // 1: two Get streams alternate.
    out_a_ready = 1'b0;
    a_step(2'b00, 1'b1, "t1stall");
    out_a_ready = 1'b1;
    push(3'b001, A0, 0);
    push(3'b111, A1, 0);
    push(3'b001, A0, 0);
    push(3'b111, A1, 0);
    a_step(2'b01, 1'b1, "t1g0");
    a_step(2'b10, 1'b1, "t1g1");
    a_step(2'b01, 1'b1, "t1g2");
    a_step(2'b10, 1'b1, "t1g3");
    in_a_valid = 2'b00;
    d_run(OP_ACK, 3'd2, 3'b001, 1, 1'b0, 1'b0);
    d_run(OP_ACK, 3'd2, 3'b001, 1, 1'b0, 1'b0);
    d_run(OP_ACK, 3'd2, 3'b111, 1, 1'b0, 1'b0);
    d_run(OP_ACK, 3'd2, 3'b111, 1, 1'b0, 1'b0);

    // 2: four-beat PutFull holds off client1.
    set_a(1, 1'b1, OP_GET, 3'd2, 2'b00, A1, 0);
    for (int k = 0; k < 4; k++) begin
      set_a(0, 1'b1, OP_PUTF, 3'd4, 2'b10, A0,
            32'hCAFE_0000 + 32'(k));
      push(3'b010, A0, 32'hCAFE_0000 + 32'(k));
      a_step(2'b01, 1'b1, "t2burst");
    end
    in_a_valid[0] = 1'b0;
    push(3'b100, A1, 0);
    a_step(2'b10, 1'b1, "t2c1");
    in_a_valid = 2'b00;
    d_run(OP_ACK, 3'd2, 3'b010, 1, 1'b0, 1'b0);
    d_run(OP_ACK, 3'd2, 3'b100, 1, 1'b0, 1'b0);

    // 3: fifth Get waits for a credit.
    for (int k = 0; k < 4; k++) begin
      set_a(0, 1'b1, OP_GET, 3'd2, 2'b11,
            A0 + 32'(4*k), 0);
      push(3'b011, A0 + 32'(4*k), 0);
      a_step(2'b01, 1'b1, "t3get");
    end
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b11, A0 + 32'd16, 0);
    a_step(2'b00, 1'b0, "t3blk");
    d_run(OP_ACKD, 3'd2, 3'b011, 1, 1'b0, 1'b1);
    push(3'b011, A0 + 32'd16, 0);
    a_step(2'b01, 1'b1, "t3resume");
    in_a_valid = 2'b00;

    // 5: accept and retire together leave credit unchanged.
    d_run(OP_ACK, 3'd2, 3'b011, 1, 1'b0, 1'b0);
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b11, A0 + 32'd32, 0);
    out_d_valid  = 1'b1;
    out_d_opcode = OP_ACK;
    out_d_size   = 3'd2;
    out_d_source = 3'b011;
    in_d_ready   = 2'b11;
    push(3'b011, A0 + 32'd32, 0);
    #1;
    chk("t5.dvld", 64'(in_d_valid), 64'(2'b01));
    chk("t5.drdy", 64'(out_d_ready), 64'(1));
    a_step(2'b01, 1'b1, "t5both");
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b11, A0 + 32'd36, 0);
    push(3'b011, A0 + 32'd36, 0);
    a_step(2'b01, 1'b1, "t5last");
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b11, A0 + 32'd40, 0);
    a_step(2'b00, 1'b0, "t5full");
    in_a_valid = 2'b00;
    for (int k = 0; k < 4; k++)
      d_run(OP_ACK, 3'd2, 3'b011, 1, 1'b0, 1'b0);

    // 4: burst response on client1, credit freed at beat 4.
    for (int k = 0; k < 4; k++) begin
      set_a(1, 1'b1, OP_GET, 3'd2, 2'b10,
            A1 + 32'(4*k), 0);
      push(3'b110, A1 + 32'(4*k), 0);
      a_step(2'b10, 1'b1, "t4get");
    end
    set_a(1, 1'b1, OP_GET, 3'd2, 2'b10, A1 + 32'd16, 0);
    d_run(OP_ACKD, 3'd4, 3'b110, 4, 1'b1, 1'b1);
    push(3'b110, A1 + 32'd16, 0);
    a_step(2'b10, 1'b1, "t4resume");
    in_a_valid = 2'b00;
    for (int k = 0; k < 4; k++)
      d_run(OP_ACK, 3'd2, 3'b110, 1, 1'b0, 1'b0);

    // 6: reset in the middle of a burst.
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b01, A0, 0);
    push(3'b001, A0, 0);
    a_step(2'b01, 1'b1, "t6pre");
    set_a(0, 1'b1, OP_PUTF, 3'd4, 2'b00, A0, 32'h11);
    push(3'b000, A0, 32'h11);
    a_step(2'b01, 1'b1, "t6b1");
    set_a(0, 1'b1, OP_PUTF, 3'd4, 2'b00, A0, 32'h22);
    set_a(1, 1'b1, OP_GET, 3'd2, 2'b11, A1, 0);
    out_d_valid  = 1'b1;
    out_d_source = 3'b000;
    in_d_ready   = 2'b11;
    reset        = 1'b0;
    #1;
    chk("t6.avld", 64'(out_a_valid), 64'(0));
    chk("t6.ardy", 64'(in_a_ready), 64'(0));
    chk("t6.dvld", 64'(in_d_valid), 64'(0));
    chk("t6.drdy", 64'(out_d_ready), 64'(0));
    @(negedge clock);
    out_d_valid = 1'b0;
    in_d_ready  = 2'b00;
    reset       = 1'b1;
    set_a(0, 1'b1, OP_GET, 3'd2, 2'b01, A0, 0);
    push(3'b001, A0, 0);
    push(3'b111, A1, 0);
    a_step(2'b01, 1'b1, "t6tie");
    a_step(2'b10, 1'b1, "t6next");
    in_a_valid = 2'b00;

    chk("sb.drained", 64'(sbq.size()), 64'(0));
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
